// File: rtl/ark_round_pipe.sv
// ark_round_pipe: registered AddRoundKey stage, state ^ bank[round] with auto-advancing round index
// Ports: clk/reset (sync, active-high); key_wr_en/idx/data write the key bank;
//   in_valid/in_ready/in_first/in_state upstream beat; out_valid/out_ready/out_state/out_round/out_last
//   downstream beat (1-cycle latency); key_err pulses when a key write is refused.
// Optional feature macro: ARK_KEY_LOCK_EN refuses key writes while a block is partially processed.
module ark_round_pipe #(
    parameter int DIM = 2,
    parameter int WORD_W = 2,
    parameter int NUM_ROUNDS = 4,
    localparam int STATE_W = DIM * DIM * WORD_W,
    localparam int IDX_W = $clog2(NUM_ROUNDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_wr_en,
    input  logic [IDX_W-1:0]   key_wr_idx,
    input  logic [STATE_W-1:0] key_wr_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [IDX_W-1:0]   out_round,
    output logic               out_last,
    output logic               key_err
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W:0] NR = (IDX_W + 1)'(NUM_ROUNDS);
    logic [STATE_W-1:0] bank [NUM_ROUNDS];
    logic [IDX_W-1:0] rnd_cnt, rnd;
    logic accept, busy, wr_ok;
    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    assign rnd = in_first ? '0 : rnd_cnt;
    assign busy = rnd_cnt != '0;
`ifdef ARK_KEY_LOCK_EN
    // Any accept with in_first=0 while busy is already covered by busy itself.
    assign wr_ok = key_wr_en && ({1'b0, key_wr_idx} < NR) && !busy;
    always_ff @(posedge clk)
        key_err <= reset ? 1'b0 : key_wr_en && busy;
`else
    assign wr_ok = key_wr_en && ({1'b0, key_wr_idx} < NR);
    assign key_err = 1'b0;
`endif
    // Bank read and write share the edge, so an accept sees the pre-write key.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_last <= 1'b0;
            rnd_cnt <= '0;
            for (int i = 0; i < NUM_ROUNDS; i++) bank[i] <= '0;
        end else begin
            if (wr_ok) bank[key_wr_idx] <= key_wr_data;
            if (accept) begin
                out_state <= in_state ^ bank[rnd];
                out_round <= rnd;
                out_last <= rnd == LAST;
                out_valid <= 1'b1;
                rnd_cnt <= (rnd == LAST) ? '0 : rnd + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
